// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_slot
// Brief    : One-entry registered valid/data slot for one downstream channel.
//            Pipeline-ready: the slot accepts a word whenever it is empty or
//            its current word is being consumed in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_rdy,
  output logic         vld,
  output logic [W-1:0] data,
  output logic         free
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next-state: a write wins over a drain so drain+write keeps vld high.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (wr_en) begin
      vld_d  = 1'b1;
      data_d = wr_data;
    end else if (rd_rdy) begin
      vld_d  = 1'b0;
    end
  end

  // Slot registers; data holds its last value after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;
  assign free = ~vld_q | rd_rdy;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Brief    : Valid/ready stream demultiplexer. One upstream channel is routed
//            to one of N downstream one-entry slots selected by up_sel.
//            Out-of-range selects are swallowed and flagged on err_sel.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux #(
  parameter  int W    = 8,
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_vld,
  output logic            up_rdy,
  input  logic [SELW-1:0] up_sel,
  input  logic [W-1:0]    up_data,
  output logic [N-1:0]    down_vld,
  input  logic [N-1:0]    down_rdy,
  output logic [N*W-1:0]  down_data,
  output logic            err_sel
);

  // Channel count widened by one bit so the range compare never truncates.
  localparam logic [SELW:0] c_NCH = (SELW+1)'(N);

  logic [N-1:0] w_free;
  logic [N-1:0] w_wr_en;
  logic         w_in_range;
  logic         w_sel_free;
  logic         err_sel_q;
  logic         err_sel_d;

  assign w_in_range = ({1'b0, up_sel} < c_NCH);

  // Select the free flag of the addressed slot; invalid selects are always
  // accepted so the upstream never blocks on a word that has no destination.
  always_comb begin
    w_sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (up_sel == SELW'(k)) begin
        w_sel_free = w_free[k];
      end
    end
    up_rdy = w_in_range ? w_sel_free : 1'b1;
  end

  // One-hot write enable: only the addressed slot, only on a real handshake.
  always_comb begin
    w_wr_en = '0;
    for (int k = 0; k < N; k++) begin
      w_wr_en[k] = up_vld & (up_sel == SELW'(k)) & w_free[k];
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_slot
      stream_demux_slot #(
        .W (W)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en[k]),
        .wr_data (up_data),
        .rd_rdy  (down_rdy[k]),
        .vld     (down_vld[k]),
        .data    (down_data[k*W +: W]),
        .free    (w_free[k])
      );
    end
  endgenerate

  assign err_sel_d = up_vld & ~w_in_range;

  // Dropped-word flag, a single-cycle pulse one cycle after the bad transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel_q <= 1'b0;
    end else begin
      err_sel_q <= err_sel_d;
    end
  end

  assign err_sel = err_sel_q;

endmodule
`default_nettype wire
